// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared float width, probability type and max-select state encoding
package viterbi_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] MAG_MASK = 32'h7fff_ffff;
  typedef logic [FP_W-1:0] fp32_t;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/viterbi_max_select_prob_gt.sv
// prob_gt: unsigned magnitude compare of two float32 probabilities, sign masked
module prob_gt
  import viterbi_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  gt
);
  assign gt = (a & MAG_MASK) > (b & MAG_MASK);
endmodule

// File: rtl/viterbi_max_select.sv
// viterbi_max_select: keeps the largest probability of each beat group and its beat index
module viterbi_max_select
  import viterbi_pkg::*;
#(
  parameter int N_STATES = 4,
  localparam int IDX_W = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp32_t            in_prob,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output fp32_t            out_prob,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_err
);
  localparam logic [IDX_W:0] N_CNT = (IDX_W + 1)'(N_STATES);
  state_t           state_q, state_d;
  fp32_t            best_q, best_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic             gt, acc, first, close, leave;
  prob_gt u_gt (.a(in_prob), .b(best_q), .gt(gt));
  assign in_ready  = state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign out_prob  = out_valid ? best_q : '0;
  assign out_idx   = out_valid ? idx_q : '0;
  assign out_err   = out_valid && err_q;
  always_comb begin
    acc     = in_valid && in_ready;
    first   = state_q == IDLE;
    leave   = out_valid && out_ready;
    cnt_inc = first ? (IDX_W + 1)'(1) : cnt_q + 1'b1;
    // a group ends on in_last or when the N_STATES-th beat arrives
    close   = acc && (in_last || cnt_inc == N_CNT);
    state_d = out_valid ? (out_ready ? IDLE : HOLD) : close ? HOLD : acc ? ACCUM : state_q;
    best_d  = leave ? '0 : (acc && (first || gt)) ? (in_prob & MAG_MASK) : best_q;
    idx_d   = leave ? '0 : acc ? (first ? '0 : gt ? cnt_q[IDX_W-1:0] : idx_q) : idx_q;
    cnt_d   = leave ? '0 : acc ? cnt_inc : cnt_q;
    err_d   = leave ? 1'b0 : close ? !in_last : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_viterbi_max_select.sv
// tb_viterbi_max_select: directed and random groups checked against a queue-based model
module tb_viterbi_max_select;
  localparam int N = 4;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_prob = '0;
  logic        in_last = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_prob;
  logic [1:0]  out_idx;
  logic        out_err;
  int total = 0;
  int bad = 0;
  logic [31:0] grp[$];
  logic        m_pend = 0;
  logic [31:0] m_prob = '0;
  int          m_idx = 0;
  logic        m_err = 0;
  logic [31:0] pool[8] = '{32'h3e80_0000, 32'h3f80_0000, 32'h3f00_0000, 32'h4000_0000,
                           32'hbf80_0000, 32'h0000_0000, 32'h7f80_0001, 32'hc000_0000};

  viterbi_max_select #(.N_STATES(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_prob(in_prob),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_prob(out_prob),
    .out_idx(out_idx), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic close_group(input logic last);
    logic [31:0] b;
    int bi;
    b = grp[0] & 32'h7fff_ffff;
    bi = 0;
    for (int i = 1; i < grp.size(); i++)
      if ((grp[i] & 32'h7fff_ffff) > b) begin
        b = grp[i] & 32'h7fff_ffff;
        bi = i;
      end
    m_pend = 1;
    m_prob = b;
    m_idx = bi;
    m_err = !last;
    grp.delete();
  endtask

  task automatic step(input logic v, input logic [31:0] p, input logic l, input logic r,
                      input logic rs);
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, !m_pend});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_pend});
    chk("out_prob", out_prob, m_pend ? m_prob : 32'h0);
    chk("out_idx", {30'b0, out_idx}, m_pend ? 32'(m_idx) : 32'h0);
    chk("out_err", {31'b0, out_err}, {31'b0, m_pend && m_err});
    in_valid = v;
    in_prob = p;
    in_last = l;
    out_ready = r;
    rst = rs;
    if (rs) begin
      grp.delete();
      m_pend = 0;
    end else if (m_pend) begin
      if (r) m_pend = 0;
    end else if (v) begin
      grp.push_back(p);
      if (l || grp.size() == N) close_group(l);
    end
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    step(1, 32'h3e80_0000, 0, 0, 0);
    step(1, 32'h3f80_0000, 0, 0, 0);
    step(1, 32'h3f00_0000, 0, 0, 0);
    step(1, 32'h4000_0000, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h3f80_0000, 0, 0, 0);
    step(1, 32'h3f80_0000, 0, 0, 0);
    step(1, 32'h3e80_0000, 0, 0, 0);
    step(1, 32'h0000_0000, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'hbf00_0000, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, pool[i], 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h4040_0000, 1, 0, 0);
    step(1, 32'h4040_0000, 1, 1, 0);
    step(1, 32'h4040_0000, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h4080_0000, 0, 0, 0);
    step(1, 32'h40a0_0000, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h3f00_0000, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : $urandom;
      step($urandom_range(0, 3) != 0, p, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 60) == 0);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
